// File: rtl/game_sequencer.sv
// ---------------------------------------------------------------------------
// game_sequencer
//   Central game-flow controller for the raccoon/car crossing game. Owns the
//   game state, level and lives registers and sequences the hit, level-up,
//   win and game-over phases on video frame ticks. Drives the freeze,
//   respawn and invulnerability controls used by the raccoon and car
//   controllers, the lives LEDs and the segment decoder.
//
// Ports:
//   i_Clk          system clock
//   i_Reset_n      asynchronous active-low reset
//   i_Frame_Tick   one-cycle pulse per video frame
//   i_Start        start request level, edge-detected internally
//   i_Abort        synchronous abort level, highest priority
//   i_Collision    raccoon/car overlap level
//   i_Goal         raccoon reached the top row level
//   o_Game_State   00 idle, 01 running, 10 win, 11 game over
//   o_Level        current level, 0..MAX_LEVEL
//   o_Lives        remaining lives
//   o_Freeze       cars and raccoon hold position
//   o_Respawn      one-cycle pulse, raccoon returns to start position
//   o_Level_Up     one-cycle pulse on level increment
//   o_Invulnerable grace window active, collisions ignored
// ---------------------------------------------------------------------------
module game_sequencer #(
  parameter int NUM_LIVES      = 3,
  parameter int MAX_LEVEL      = 9,
  parameter int HIT_FRAMES     = 60,
  parameter int LEVELUP_FRAMES = 30,
  parameter int GRACE_FRAMES   = 90,
  parameter int FRAME_CNT_W    = 7
) (
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic       i_Frame_Tick,
  input  logic       i_Start,
  input  logic       i_Abort,
  input  logic       i_Collision,
  input  logic       i_Goal,
  output logic [1:0] o_Game_State,
  output logic [3:0] o_Level,
  output logic [3:0] o_Lives,
  output logic       o_Freeze,
  output logic       o_Respawn,
  output logic       o_Level_Up,
  output logic       o_Invulnerable
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUNNING,
    S_HIT,
    S_LEVEL_UP,
    S_WIN,
    S_GAME_OVER
  } state_t;

  localparam logic [3:0]             LIVES_INIT = 4'(NUM_LIVES);
  localparam logic [3:0]             LEVEL_MAX  = 4'(MAX_LEVEL);
  localparam logic [FRAME_CNT_W-1:0] GRACE_LOAD = FRAME_CNT_W'(GRACE_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] HIT_LAST   = FRAME_CNT_W'(HIT_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] LU_LAST    = FRAME_CNT_W'(LEVELUP_FRAMES - 1);

  state_t                 state_q, state_d;
  logic [3:0]             level_q, level_d;
  logic [3:0]             lives_q, lives_d;
  logic [FRAME_CNT_W-1:0] phase_q, phase_d;
  logic [FRAME_CNT_W-1:0] grace_q, grace_d;
  logic                   respawn_q, respawn_d;
  logic                   level_up_q, level_up_d;
  logic [1:0]             game_state_q, game_state_d;
  logic                   freeze_q, freeze_d;
  logic                   invuln_q, invuln_d;
  logic                   start_q;
  logic                   start_edge;

  // start_q resets high so a start switch held through reset is not seen
  // as a fresh request; abort masks the edge in the same cycle.
  assign start_edge = i_Start & ~start_q & ~i_Abort;

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    lives_d    = lives_q;
    phase_d    = phase_q;
    grace_d    = grace_q;
    respawn_d  = 1'b0;
    level_up_d = 1'b0;

    if (i_Abort) begin
      state_d = S_IDLE;
      level_d = 4'd0;
      lives_d = LIVES_INIT;
      phase_d = '0;
      grace_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_WIN, S_GAME_OVER: begin
          if (start_edge) begin
            state_d   = S_RUNNING;
            level_d   = 4'd0;
            lives_d   = LIVES_INIT;
            phase_d   = '0;
            grace_d   = GRACE_LOAD;
            respawn_d = 1'b1;
          end
        end

        S_RUNNING: begin
          if (i_Frame_Tick && (grace_q != '0)) begin
            grace_d = grace_q - 1'b1;
          end
          // A counted collision takes precedence over a goal in the same cycle.
          if (i_Collision && (grace_q == '0)) begin
            if (lives_q <= 4'd1) begin
              lives_d = 4'd0;
              state_d = S_GAME_OVER;
            end else begin
              lives_d = lives_q - 4'd1;
              phase_d = '0;
              state_d = S_HIT;
            end
          end else if (i_Goal) begin
            if (level_q >= LEVEL_MAX - 4'd1) begin
              level_d = LEVEL_MAX;
              state_d = S_WIN;
            end else begin
              level_d    = level_q + 4'd1;
              level_up_d = 1'b1;
              phase_d    = '0;
              state_d    = S_LEVEL_UP;
            end
          end
        end

        S_HIT: begin
          if (i_Frame_Tick) begin
            if (phase_q == HIT_LAST) begin
              state_d   = S_RUNNING;
              phase_d   = '0;
              grace_d   = GRACE_LOAD;
              respawn_d = 1'b1;
            end else begin
              phase_d = phase_q + 1'b1;
            end
          end
        end

        S_LEVEL_UP: begin
          if (i_Frame_Tick) begin
            if (phase_q == LU_LAST) begin
              state_d   = S_RUNNING;
              phase_d   = '0;
              grace_d   = GRACE_LOAD;
              respawn_d = 1'b1;
            end else begin
              phase_d = phase_q + 1'b1;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Status outputs are decoded from the next state so they change on the
  // same edge as the transition that causes them.
  always_comb begin
    case (state_d)
      S_IDLE:      game_state_d = 2'b00;
      S_WIN:       game_state_d = 2'b10;
      S_GAME_OVER: game_state_d = 2'b11;
      default:     game_state_d = 2'b01;
    endcase
    freeze_d = (state_d != S_RUNNING);
    invuln_d = (grace_d != '0);
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q      <= S_IDLE;
      level_q      <= 4'd0;
      lives_q      <= LIVES_INIT;
      phase_q      <= '0;
      grace_q      <= '0;
      respawn_q    <= 1'b0;
      level_up_q   <= 1'b0;
      game_state_q <= 2'b00;
      freeze_q     <= 1'b1;
      invuln_q     <= 1'b0;
      start_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
      phase_q      <= phase_d;
      grace_q      <= grace_d;
      respawn_q    <= respawn_d;
      level_up_q   <= level_up_d;
      game_state_q <= game_state_d;
      freeze_q     <= freeze_d;
      invuln_q     <= invuln_d;
      start_q      <= i_Start;
    end
  end

  assign o_Game_State   = game_state_q;
  assign o_Level        = level_q;
  assign o_Lives        = lives_q;
  assign o_Freeze       = freeze_q;
  assign o_Respawn      = respawn_q;
  assign o_Level_Up     = level_up_q;
  assign o_Invulnerable = invuln_q;

endmodule

// File: tb/tb_game_sequencer.sv
// ---------------------------------------------------------------------------
// tb_game_sequencer
//   Self-checking bench for game_sequencer with default parameters.
//   A table of {pre-tick count, inputs, expected outputs} records drives the
//   main game flow; expected outputs go through a scoreboard queue and are
//   compared one clock edge later. Async reset is exercised by hand.
// ---------------------------------------------------------------------------
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_Frame_Tick, i_Start, i_Abort, i_Collision, i_Goal;
  logic [1:0] o_Game_State;
  logic [3:0] o_Level, o_Lives;
  logic       o_Freeze, o_Respawn, o_Level_Up, o_Invulnerable;

  always #5 clk = ~clk;

  game_sequencer dut (
    .i_Clk          (clk),
    .i_Reset_n      (rst_n),
    .i_Frame_Tick   (i_Frame_Tick),
    .i_Start        (i_Start),
    .i_Abort        (i_Abort),
    .i_Collision    (i_Collision),
    .i_Goal         (i_Goal),
    .o_Game_State   (o_Game_State),
    .o_Level        (o_Level),
    .o_Lives        (o_Lives),
    .o_Freeze       (o_Freeze),
    .o_Respawn      (o_Respawn),
    .o_Level_Up     (o_Level_Up),
    .o_Invulnerable (o_Invulnerable)
  );

  typedef struct packed {
    logic tick;
    logic start;
    logic abort;
    logic coll;
    logic goal;
  } in_t;

  typedef struct packed {
    logic [1:0] gs;
    logic [3:0] lvl;
    logic [3:0] lives;
    logic       frz;
    logic       rsp;
    logic       lup;
    logic       inv;
  } out_t;

  typedef struct packed {
    int   pre;
    in_t  in;
    out_t ex;
  } vec_t;

  vec_t  tbl[$];
  string names[$];
  out_t  exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  function automatic in_t vi(logic tick, logic start, logic abort, logic coll, logic goal);
    in_t r;
    r.tick = tick; r.start = start; r.abort = abort; r.coll = coll; r.goal = goal;
    return r;
  endfunction

  function automatic out_t vo(logic [1:0] gs, int lvl, int lives,
                              logic frz, logic rsp, logic lup, logic inv);
    out_t r;
    r.gs = gs; r.lvl = 4'(lvl); r.lives = 4'(lives);
    r.frz = frz; r.rsp = rsp; r.lup = lup; r.inv = inv;
    return r;
  endfunction

  task automatic add(input int pre, input in_t in, input out_t ex, input string nm);
    vec_t v;
    v.pre = pre; v.in = in; v.ex = ex;
    tbl.push_back(v);
    names.push_back(nm);
  endtask

  // One level-up round: expire grace, take the goal, then the 30-tick freeze.
  task automatic add_level(input int k, input int lives);
    add(90, vi(0,0,0,0,1), vo(2'b01, k, lives, 1, 0, 1, 0), $sformatf("goal_l%0d", k));
    add(28, vi(1,0,0,0,0), vo(2'b01, k, lives, 1, 0, 0, 0), $sformatf("lu_hold_l%0d", k));
    add(0,  vi(1,0,0,0,0), vo(2'b01, k, lives, 0, 1, 0, 1), $sformatf("lu_exit_l%0d", k));
  endtask

  task automatic check(input string nm);
    out_t got, ex;
    got = {o_Game_State, o_Level, o_Lives, o_Freeze, o_Respawn, o_Level_Up, o_Invulnerable};
    ex  = exp_q.pop_front();
    n_vec++;
    if (got !== ex) begin
      n_err++;
      $display("FAIL %s: got gs=%b lvl=%0d lives=%0d frz=%b rsp=%b lup=%b inv=%b, expected gs=%b lvl=%0d lives=%0d frz=%b rsp=%b lup=%b inv=%b",
               nm, got.gs, got.lvl, got.lives, got.frz, got.rsp, got.lup, got.inv,
               ex.gs, ex.lvl, ex.lives, ex.frz, ex.rsp, ex.lup, ex.inv);
    end else begin
      $display("ok   %s: gs=%b lvl=%0d lives=%0d frz=%b rsp=%b lup=%b inv=%b",
               nm, got.gs, got.lvl, got.lives, got.frz, got.rsp, got.lup, got.inv);
    end
  endtask

  task automatic set_inputs(input in_t in);
    i_Frame_Tick = in.tick;
    i_Start      = in.start;
    i_Abort      = in.abort;
    i_Collision  = in.coll;
    i_Goal       = in.goal;
  endtask

  task automatic tick_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      set_inputs(vi(1,0,0,0,0));
    end
  endtask

  task automatic drive_check(input in_t in, input out_t ex, input string nm);
    @(negedge clk);
    set_inputs(in);
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    check(nm);
  endtask

  task automatic peek(input out_t ex, input string nm);
    exp_q.push_back(ex);
    check(nm);
  endtask

  initial begin
    // ---- build the vector table ----
    add(0, vi(0,1,0,0,0), vo(2'b00, 0, 3, 1, 0, 0, 0), "start_held");
    add(0, vi(0,0,0,0,0), vo(2'b00, 0, 3, 1, 0, 0, 0), "idle");
    add(0, vi(0,1,0,0,0), vo(2'b01, 0, 3, 0, 1, 0, 1), "start");
    add(0, vi(0,1,0,0,0), vo(2'b01, 0, 3, 0, 0, 0, 1), "run");
    add(88, vi(1,0,0,0,0), vo(2'b01, 0, 3, 0, 0, 0, 1), "grace_last");
    add(0, vi(1,0,0,0,0), vo(2'b01, 0, 3, 0, 0, 0, 0), "grace_end");
    add(0, vi(0,0,0,1,0), vo(2'b01, 0, 2, 1, 0, 0, 0), "hit");
    add(0, vi(0,0,0,1,0), vo(2'b01, 0, 2, 1, 0, 0, 0), "hit_coll_ignored");
    add(58, vi(1,0,0,0,0), vo(2'b01, 0, 2, 1, 0, 0, 0), "hit_hold");
    add(0, vi(1,0,0,0,0), vo(2'b01, 0, 2, 0, 1, 0, 1), "hit_exit");
    add(0, vi(0,0,0,1,0), vo(2'b01, 0, 2, 0, 0, 0, 1), "grace_coll");
    add(90, vi(0,0,0,1,0), vo(2'b01, 0, 1, 1, 0, 0, 0), "hit2");
    add(59, vi(1,0,0,0,0), vo(2'b01, 0, 1, 0, 1, 0, 1), "hit2_exit");
    add(90, vi(0,0,0,1,0), vo(2'b11, 0, 0, 1, 0, 0, 0), "game_over");
    add(5, vi(1,0,0,1,0), vo(2'b11, 0, 0, 1, 0, 0, 0), "go_hold");
    add(0, vi(0,1,0,0,0), vo(2'b01, 0, 3, 0, 1, 0, 1), "restart");
    for (int k = 1; k <= 8; k++) add_level(k, 3);
    add(90, vi(0,0,0,0,1), vo(2'b10, 9, 3, 1, 0, 0, 0), "win");
    add(3, vi(0,0,0,0,1), vo(2'b10, 9, 3, 1, 0, 0, 0), "win_hold");
    add(0, vi(0,1,0,0,0), vo(2'b01, 0, 3, 0, 1, 0, 1), "win_restart");
    for (int k = 1; k <= 3; k++) add_level(k, 3);
    add(90, vi(0,0,0,1,1), vo(2'b01, 3, 2, 1, 0, 0, 0), "coll_and_goal");
    add(59, vi(1,0,0,0,0), vo(2'b01, 3, 2, 0, 1, 0, 1), "cg_exit");
    for (int k = 4; k <= 5; k++) add_level(k, 2);
    add(90, vi(0,0,0,1,0), vo(2'b01, 5, 1, 1, 0, 0, 0), "hit_l5");
    add(10, vi(0,0,1,0,0), vo(2'b00, 0, 3, 1, 0, 0, 0), "abort");
    add(0, vi(0,1,1,0,0), vo(2'b00, 0, 3, 1, 0, 0, 0), "abort_masks_start");
    add(0, vi(0,0,0,0,0), vo(2'b00, 0, 3, 1, 0, 0, 0), "idle2");
    add(0, vi(0,1,0,0,0), vo(2'b01, 0, 3, 0, 1, 0, 1), "start3");
    add(0, vi(0,0,0,0,1), vo(2'b01, 1, 3, 1, 0, 1, 1), "lu_in_grace");
    add(5, vi(1,0,0,0,0), vo(2'b01, 1, 3, 1, 0, 0, 1), "lu_mid");

    // ---- reset with start held ----
    rst_n = 1'b0;
    set_inputs(vi(0,1,0,0,0));
    repeat (3) @(posedge clk);
    #1;
    peek(vo(2'b00, 0, 3, 1, 0, 0, 0), "reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table-driven flow ----
    for (int i = 0; i < tbl.size(); i++) begin
      tick_cycles(tbl[i].pre);
      drive_check(tbl[i].in, tbl[i].ex, names[i]);
    end

    // ---- async reset mid-LEVEL_UP, checked between clock edges ----
    @(negedge clk);
    rst_n = 1'b0;
    set_inputs(vi(0,1,0,0,0));
    #2;
    peek(vo(2'b00, 0, 3, 1, 0, 0, 0), "async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive_check(vi(0,1,0,0,0), vo(2'b00, 0, 3, 1, 0, 0, 0), "rst_start_held");
    drive_check(vi(0,0,0,0,0), vo(2'b00, 0, 3, 1, 0, 0, 0), "rst_idle");
    drive_check(vi(0,1,0,0,0), vo(2'b01, 0, 3, 0, 1, 0, 1), "rst_start");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Central game-flow controller for the raccoon/car crossing game. It owns the game state, level and lives registers. It sequences the hit, level-up, win and game-over phases on frame ticks, and drives the freeze, respawn and invulnerability controls consumed by raccoon_ctrl, the car_ctrl instances, the lives LEDs and the segment decoder. It replaces ad-hoc level and lives bookkeeping in top with a single FSM.

Parameters:
NUM_LIVES, 3, lives loaded at reset/new game (1..15)
MAX_LEVEL, 9, level value that declares a win
HIT_FRAMES, 60, frozen frames after a collision before respawn
LEVELUP_FRAMES, 30, frozen frames between levels
GRACE_FRAMES, 90, post-respawn frames during which collisions are ignored
FRAME_CNT_W, 7, phase/grace counter width; must hold max(HIT_FRAMES, LEVELUP_FRAMES, GRACE_FRAMES)

Ports:
i_Clk  in  1  system clock
i_Reset_n  in  1  asynchronous active-low reset
i_Frame_Tick  in  1  one-cycle pulse per video frame (VSync edge)
i_Start  in  1  start request level (switch combo); edge-detected internally
i_Abort  in  1  synchronous abort level (all four switches)
i_Collision  in  1  raccoon/car overlap, level
i_Goal  in  1  raccoon reached top row, level
o_Game_State  out  2  00 idle, 01 running, 10 win, 11 game over
o_Level  out  4  current level, 0..MAX_LEVEL
o_Lives  out  4  remaining lives
o_Freeze  out  1  1 = cars and raccoon hold position
o_Respawn  out  1  one-cycle pulse: raccoon returns to start position
o_Level_Up  out  1  one-cycle pulse on level increment
o_Invulnerable  out  1  grace window active

Behaviour:
- Clocking and reset: one clock domain; reset is asynchronous and active-low; all state is in registers on posedge i_Clk.
- Reset values: FSM = IDLE, o_Game_State = 00, o_Level = 0, o_Lives = NUM_LIVES, o_Freeze = 1, o_Respawn = 0, o_Level_Up = 0, o_Invulnerable = 0, phase counter = 0, grace counter = 0.
- Start edge register resets to 1, so a start held through reset does not launch a game.
- start_edge = i_Start & ~start_q & ~i_Abort.
- FSM states: IDLE, RUNNING, HIT, LEVEL_UP, WIN, GAME_OVER.
- o_Game_State mapping: IDLE = 00; RUNNING, HIT and LEVEL_UP = 01; WIN = 10; GAME_OVER = 11.
- o_Freeze = 1 in every state except RUNNING.
- Outputs are registered: each output changes on the same edge as the FSM transition that causes it.
- i_Abort has top priority in any state. Next cycle: IDLE, level 0, lives NUM_LIVES, grace 0, no pulses.
- IDLE, WIN, GAME_OVER, on start_edge: go to RUNNING; level 0; lives NUM_LIVES; o_Respawn pulse; grace = GRACE_FRAMES.
- RUNNING, collision path:
  - If i_Collision and grace == 0: lives decrements.
  - If lives was 1: go to GAME_OVER with lives 0.
  - Otherwise: go to HIT with phase counter 0.
- RUNNING, goal path: taken if i_Goal and no collision is taken in the same cycle. Collision wins when both occur.
  - If level + 1 == MAX_LEVEL: level = MAX_LEVEL, go to WIN.
  - Otherwise: level + 1, o_Level_Up pulse, go to LEVEL_UP with phase counter 0.
- RUNNING, grace counter: decrements on each i_Frame_Tick while nonzero. o_Invulnerable = (grace != 0).
- HIT: phase counter increments on i_Frame_Tick. On a tick with counter == HIT_FRAMES-1: go to RUNNING, o_Respawn pulse, grace = GRACE_FRAMES. Exit occurs on the HIT_FRAMES-th tick.
- LEVEL_UP: same as HIT but uses LEVELUP_FRAMES. On exit: o_Respawn pulse, grace = GRACE_FRAMES.
- Grace counter is held (not decremented) in HIT and LEVEL_UP.
- i_Collision and i_Goal are ignored outside RUNNING. Lives and level never wrap: no decrement below 0, no increment above MAX_LEVEL.
- Timed states with no frame ticks remain indefinitely. This is not an error.

Test Plan:
- Reset held low, i_Start=1; release reset with i_Start still 1 -> stays IDLE, o_Freeze=1, o_Lives=3; drop then raise i_Start -> next cycle RUNNING (o_Game_State=01), o_Respawn one cycle, o_Invulnerable=1.
- In RUNNING after 90 frame ticks (grace 0), assert i_Collision -> HIT, o_Lives 3->2, o_Freeze=1; on the 60th tick -> RUNNING, o_Respawn pulse, grace reloaded to 90; collision during grace -> ignored, lives stay 2.
- Three collisions, each after grace expiry -> o_Lives 3,2,1,0; third collision goes directly to GAME_OVER (11), not HIT; start_edge -> RUNNING, lives 3, level 0.
- Drive i_Goal once per LEVEL_UP completion from level 0 -> o_Level_Up pulses, level 1..8 with 30-tick freeze each; goal at level 8 -> level 9, WIN (10), no o_Level_Up pulse.
- i_Collision and i_Goal asserted in the same cycle, grace 0, level 3 -> HIT taken, lives decrement, level stays 3.
- i_Abort mid-HIT at level 5, lives 1 -> next cycle IDLE, level 0, lives 3, no o_Respawn pulse; i_Reset_n low mid-LEVEL_UP -> all outputs immediately at reset values without waiting for a clock edge.
